window_stats: RTL and testbench

WINDOW_STATS -- requirements
Module: window_stats

---
 rtl/window_stats_pkg.sv | 28 ++
 rtl/window_stats_lane_acc.sv | 57 +++++
 rtl/window_stats.sv | 150 +++++++++++++++
 tb/tb_window_stats.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_stats_pkg.sv
// Shared types and width helpers for the window_stats block.
package window_stats_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    function automatic int calc_sum_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    function automatic int calc_sq_w(input int data_w, input int log2_n);
        return 2 * data_w + log2_n;
    endfunction

    function automatic int calc_var_w(input int data_w);
        return 2 * data_w - 2;
    endfunction

    // Widths for the default configuration (DATA_W=8, LOG2_N=6)
    localparam int SUM_W = calc_sum_w(8, 6);
    localparam int SQ_W  = calc_sq_w(8, 6);
    localparam int VAR_W = calc_var_w(8);

endpackage

// File: rtl/window_stats_lane_acc.sv
// Combinational LANES-wide partial sum / sum-of-squares as binary adder trees.
// Optional min/max trees under WINDOW_STATS_MINMAX_EN.
module window_stats_lane_acc #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1,
    parameter int SUM_W  = 14,
    parameter int SQ_W   = 22
) (
    input  logic [LANES*DATA_W-1:0] lanes,
`ifdef WINDOW_STATS_MINMAX_EN
    output logic [DATA_W-1:0]       lane_min,
    output logic [DATA_W-1:0]       lane_max,
`endif
    output logic [SUM_W-1:0]        psum,
    output logic [SQ_W-1:0]         psq
);

    // Heap layout: leaves at [LANES-1 .. 2*LANES-2], node i sums children 2i+1, 2i+2
    logic [2*LANES-2:0][SUM_W-1:0] st;
    logic [2*LANES-2:0][SQ_W-1:0]  qt;
`ifdef WINDOW_STATS_MINMAX_EN
    logic [2*LANES-2:0][DATA_W-1:0] mnt, mxt;
`endif

    always_comb begin
        st = '0;
        qt = '0;
        for (int g = 0; g < LANES; g++) begin
            st[LANES-1+g] = SUM_W'(lanes[g*DATA_W +: DATA_W]);
            qt[LANES-1+g] = SQ_W'(lanes[g*DATA_W +: DATA_W]) * SQ_W'(lanes[g*DATA_W +: DATA_W]);
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            st[i] = st[2*i+1] + st[2*i+2];
            qt[i] = qt[2*i+1] + qt[2*i+2];
        end
        psum = st[0];
        psq  = qt[0];
    end

`ifdef WINDOW_STATS_MINMAX_EN
    always_comb begin
        mnt = '0;
        mxt = '0;
        for (int g = 0; g < LANES; g++) begin
            mnt[LANES-1+g] = lanes[g*DATA_W +: DATA_W];
            mxt[LANES-1+g] = lanes[g*DATA_W +: DATA_W];
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            mnt[i] = (mnt[2*i+1] < mnt[2*i+2]) ? mnt[2*i+1] : mnt[2*i+2];
            mxt[i] = (mxt[2*i+1] > mxt[2*i+2]) ? mxt[2*i+1] : mxt[2*i+2];
        end
        lane_min = mnt[0];
        lane_max = mxt[0];
    end
`endif

endmodule

// File: rtl/window_stats.sv
// Window mean / population variance over N = 2^LOG2_N samples, LANES per cycle.
// Optional min/max outputs when WINDOW_STATS_MINMAX_EN is defined.
module window_stats
    import window_stats_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 6,
    parameter int LANES  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(1<<LOG2_N)*DATA_W-1:0]   values,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_W-1:0]               mean_value,
    output logic [2*DATA_W-3:0]             var_value,
    output logic                            out_valid,
`ifdef WINDOW_STATS_MINMAX_EN
    output logic [DATA_W-1:0]               min_value,
    output logic [DATA_W-1:0]               max_value,
`endif
    input  logic                            out_ready
);

    localparam int N      = 1 << LOG2_N;
    localparam int GROUPS = N / LANES;
    localparam int SW     = calc_sum_w(DATA_W, LOG2_N);
    localparam int QW     = calc_sq_w(DATA_W, LOG2_N);
    localparam int VW     = calc_var_w(DATA_W);
    localparam int FW     = 2 * SW + 1;

    state_t                   state, state_nxt;
    logic [N*DATA_W-1:0]      win_q;
    logic [SW-1:0]            sum;
    logic [QW-1:0]            sumsq;
    logic [LOG2_N-1:0]        cnt;
    logic [SW-1:0]            psum;
    logic [QW-1:0]            psq;
    logic [SW:0]              mean_num;
    logic [FW-1:0]            var_num;
    logic [DATA_W-1:0]        mean_nxt;
    logic [VW-1:0]            var_nxt;
    logic                     last_grp;

`ifdef WINDOW_STATS_MINMAX_EN
    logic [DATA_W-1:0] lane_min, lane_max, run_min, run_max;

    window_stats_lane_acc #(
        .DATA_W(DATA_W), .LANES(LANES), .SUM_W(SW), .SQ_W(QW)
    ) u_lane_acc (
        .lanes    (win_q[LANES*DATA_W-1:0]),
        .lane_min (lane_min),
        .lane_max (lane_max),
        .psum     (psum),
        .psq      (psq)
    );
`else
    window_stats_lane_acc #(
        .DATA_W(DATA_W), .LANES(LANES), .SUM_W(SW), .SQ_W(QW)
    ) u_lane_acc (
        .lanes    (win_q[LANES*DATA_W-1:0]),
        .psum     (psum),
        .psq      (psq)
    );
`endif

    assign last_grp = (cnt == LOG2_N'(GROUPS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ACCUM;
            end
            S_ACCUM:  if (last_grp) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_HOLD;
            S_HOLD:   if (out_valid && out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Full-width round-half-up; N*sumsq - sum^2 is N^2 * variance and never negative
    always_comb begin
        mean_num = {1'b0, sum} + (SW+1)'(N / 2);
        mean_nxt = DATA_W'(mean_num >> LOG2_N);
        var_num  = {1'b0, sumsq, {LOG2_N{1'b0}}} - FW'(sum) * FW'(sum)
                   + (FW'(1) << (2 * LOG2_N - 1));
        var_nxt  = VW'(var_num >> (2 * LOG2_N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            sum        <= '0;
            sumsq      <= '0;
            cnt        <= '0;
            mean_value <= '0;
            var_value  <= '0;
            out_valid  <= 1'b0;
`ifdef WINDOW_STATS_MINMAX_EN
            run_min    <= '0;
            run_max    <= '0;
            min_value  <= '0;
            max_value  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    win_q   <= values;
                    sum     <= '0;
                    sumsq   <= '0;
                    cnt     <= '0;
`ifdef WINDOW_STATS_MINMAX_EN
                    run_min <= '1;
                    run_max <= '0;
`endif
                end
                S_ACCUM: begin
                    sum   <= sum + psum;
                    sumsq <= sumsq + psq;
                    win_q <= win_q >> (LANES * DATA_W);
                    cnt   <= cnt + 1'b1;
`ifdef WINDOW_STATS_MINMAX_EN
                    if (lane_min < run_min) run_min <= lane_min;
                    if (lane_max > run_max) run_max <= lane_max;
`endif
                end
                S_FINISH: begin
                    mean_value <= mean_nxt;
                    var_value  <= var_nxt;
`ifdef WINDOW_STATS_MINMAX_EN
                    min_value  <= run_min;
                    max_value  <= run_max;
`endif
                end
                // out_valid is registered off HOLD, so it rises one cycle into HOLD
                S_HOLD: out_valid <= !(out_valid && out_ready);
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_window_stats.sv
// Scoreboard bench for window_stats: LANES=1 and LANES=4 instances vs a real-arithmetic model.
module tb_window_stats;

    localparam int DW  = 8;
    localparam int L2N = 6;
    localparam int N   = 1 << L2N;
    localparam int WW  = N * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [WW-1:0]     values, v4;
    logic              in_valid, iv4, in_ready, ir4;
    logic [DW-1:0]     mean_value, m4;
    logic [2*DW-3:0]   var_value, var4;
    logic              out_valid, ov4, out_ready, or4;
`ifdef WINDOW_STATS_MINMAX_EN
    logic [DW-1:0]     min_value, max_value, mn4, mx4;
`endif

    window_stats #(.DATA_W(DW), .LOG2_N(L2N), .LANES(1)) dut (
        .clk(clk), .rst(rst), .values(values), .in_valid(in_valid), .in_ready(in_ready),
        .mean_value(mean_value), .var_value(var_value), .out_valid(out_valid),
`ifdef WINDOW_STATS_MINMAX_EN
        .min_value(min_value), .max_value(max_value),
`endif
        .out_ready(out_ready)
    );

    window_stats #(.DATA_W(DW), .LOG2_N(L2N), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .values(v4), .in_valid(iv4), .in_ready(ir4),
        .mean_value(m4), .var_value(var4), .out_valid(ov4),
`ifdef WINDOW_STATS_MINMAX_EN
        .min_value(mn4), .max_value(mx4),
`endif
        .out_ready(or4)
    );

    typedef struct {
        int mean;
        int vr;
        int mn;
        int mx;
        int acc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact mean and population variance in real arithmetic, rounded half up
    function automatic exp_t model(input logic [WW-1:0] w);
        exp_t e;
        real  s, v, m;
        int   x;
        s = 0.0; v = 0.0;
        e.mn = 255; e.mx = 0; e.acc = 0;
        for (int k = 0; k < N; k++) begin
            x = int'(w[k*DW +: DW]);
            s += x;
            if (x < e.mn) e.mn = x;
            if (x > e.mx) e.mx = x;
        end
        m = s / N;
        for (int k = 0; k < N; k++) begin
            x = int'(w[k*DW +: DW]);
            v += (x - m) * (x - m);
        end
        e.mean = $rtoi($floor(m + 0.5));
        e.vr   = $rtoi($floor(v / N + 0.5));
        return e;
    endfunction

    function automatic logic [WW-1:0] rand_bus();
        logic [WW-1:0] w;
        for (int k = 0; k < WW / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    // Monitors: pop one expectation per out_valid assertion
    bit   busy1 = 1'b0, busy4 = 1'b0;
    exp_t e1, e4;

    always @(negedge clk) begin
        if (rst) busy1 = 1'b0;
        else if (out_valid && !busy1) begin
            busy1 = 1'b1;
            if (q1.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("mean", mean_value, e1.mean);
                chk("var", var_value, e1.vr);
                chk("latency", cyc - e1.acc, N + 2);
`ifdef WINDOW_STATS_MINMAX_EN
                chk("min", min_value, e1.mn);
                chk("max", max_value, e1.mx);
`endif
            end
        end else if (!out_valid) busy1 = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) busy4 = 1'b0;
        else if (ov4 && !busy4) begin
            busy4 = 1'b1;
            if (q4.size() == 0) chk("unexpected_out4", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("mean4", m4, e4.mean);
                chk("var4", var4, e4.vr);
                chk("latency4", cyc - e4.acc, N / 4 + 2);
            end
        end else if (!ov4) busy4 = 1'b0;
    end

    task automatic send(input logic [WW-1:0] w);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        chk("in_ready_wait", in_ready, 1);
        values   = w;
        in_valid = 1'b1;
        e = model(w);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q1.push_back(e);
        in_valid = 1'b0;
        values   = rand_bus();
    endtask

    task automatic run(input logic [WW-1:0] w, input int hold, input bit poke);
        exp_t ex;
        int   n = 0;
        ex = model(w);
        send(w);
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        chk("out_valid_rise", out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin values = rand_bus(); in_valid = 1'b1; end
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_mean", mean_value, ex.mean);
            chk("hold_var", var_value, ex.vr);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("no_queued_window", in_ready, 1);
        end
    endtask

    logic [WW-1:0] w;
    int            seen;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; values = '0;
        iv4 = 1'b0; or4 = 1'b0; v4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_mean", mean_value, 0);
        chk("reset_var", var_value, 0);
`ifdef WINDOW_STATS_MINMAX_EN
        chk("reset_min", min_value, 0);
        chk("reset_max", max_value, 0);
`endif

        for (int k = 0; k < N; k++) w[k*DW +: DW] = 8'd10;
        run(w, 0, 1'b0);
        for (int k = 0; k < N; k++) w[k*DW +: DW] = (k % 2) ? 8'd255 : 8'd0;
        run(w, 2, 1'b0);
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'(k);
        run(w, 1, 1'b0);

        // Long HOLD with a second window offered and ignored
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'($urandom_range(0, 255));
        run(w, 20, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++)
                w[k*DW +: DW] = (r % 2) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(100, 103));
            run(w, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset mid-ACCUM discards the window and clears outputs
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'($urandom_range(0, 255));
        send(w);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q1.pop_back());
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mean", mean_value, 0);
        chk("midrst_var", var_value, 0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_discarded", seen, 0);
        for (int k = 0; k < N; k++) w[k*DW +: DW] = 8'd200;
        run(w, 0, 1'b0);

        // LANES=4 instance, ramp window
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'(k);
        @(negedge clk);
        chk("dut4_in_ready", ir4, 1);
        v4  = w;
        iv4 = 1'b1;
        e4  = model(w);
        @(posedge clk);
        #1;
        e4.acc = cyc;
        q4.push_back(e4);
        iv4 = 1'b0;
        v4  = rand_bus();
        seen = 0;
        while (!ov4 && seen < 100) begin @(negedge clk); seen++; end
        chk("dut4_out_valid", ov4, 1);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("dut4_release", ov4, 0);

        repeat (2) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
